find_max_feeder: RTL and testbench

- Initiator side of the find_max start/in/done/max_val stream protocol.
- A host loads up to DEPTH unsigned values into a local buffer, then pulses go. The block streams the values to a find_max instance and captures max_val when done is raised.
- It also computes its own expected maximum during loading and flags any mismatch. The block doubles as a traffic source and a self-checking harness in the same clock domain.

---
 rtl/find_max_pkg.sv | 31 +++
 rtl/find_max_feed_buf.sv | 30 +++
 rtl/find_max_feeder.sv | 187 ++++++++++++++++++
 tb/tb_find_max_feeder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/find_max_pkg.sv
// Shared types for find_max and its feeder/checker.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package find_max_pkg;

  // Feeder sequencing: load/idle, stream values, wait for done, report.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } feeder_state_t;

  // find_max's own two-state machine. The FM_ prefix keeps these names
  // distinct from the feeder's IDLE inside one package scope.
  typedef enum logic {
    FM_IDLE = 1'b0,
    FM_WORK = 1'b1
  } state_t;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Width of an index into an n-entry array.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/find_max_feed_buf.sv
// Value buffer: DEPTH x WIDTH registers, one sync write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller only writes when a free slot exists.
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out (combinational).
module find_max_feed_buf
  import find_max_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [addr_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic [addr_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]             rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage needs no reset: the owner's count gates which entries are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/find_max_feeder.sv
// Drives a find_max instance from a host-loaded buffer and checks its reported max.
// Latency: go at edge 0 -> start on cycles 1..N, done sampled cycle N+1, res_valid cycle N+2.
// Backpressure: writes accepted only in IDLE while not full (wr_ready); go/clr/wr_en ignored while busy.
// Ports: host load (wr_en/wr_data/wr_ready/clr/count), control (go/busy),
//        find_max side (start/data out, done/max_val in), result (res_*).
module find_max_feeder
  import find_max_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  output logic                        wr_ready,
  input  logic                        clr,
  input  logic                        go,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        busy,
  output logic                        start,
  output logic [WIDTH-1:0]            data,
  input  logic                        done,
  input  logic [WIDTH-1:0]            max_val,
  output logic                        res_valid,
  output logic [WIDTH-1:0]            res_max,
  output logic                        res_timeout,
  output logic                        res_mismatch
);

  localparam int CW = cnt_width(DEPTH);
  localparam int AW = addr_width(DEPTH);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  feeder_state_t    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic [WIDTH-1:0] exp_max_q, exp_max_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic             res_timeout_q, res_timeout_d;
  logic             res_mismatch_q, res_mismatch_d;

  logic             full;
  logic             wr_accept;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  assign full      = (count_q == FULL_CNT);
  assign wr_ready  = (state_q == IDLE) && !full;
  // clr takes priority over a coincident write.
  assign wr_accept = wr_en && wr_ready && !clr;
  assign busy      = (state_q != IDLE);

  // idx_q always holds the index of the next value to present; on go the
  // first value comes from entry 0, so the read port points there in IDLE.
  assign rd_addr = (state_q == STREAM) ? idx_q[AW-1:0] : '0;

  find_max_feed_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (count_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    idx_d          = idx_q;
    wcnt_d         = wcnt_q;
    exp_max_d      = exp_max_q;
    start_d        = start_q;
    data_d         = data_q;
    res_valid_d    = 1'b0;
    res_max_d      = res_max_q;
    res_timeout_d  = res_timeout_q;
    res_mismatch_d = res_mismatch_q;

    unique case (state_q)
      IDLE: begin
        if (clr) begin
          count_d   = '0;
          exp_max_d = '0;
        end else begin
          if (wr_accept) begin
            count_d   = count_q + CW'(1);
            exp_max_d = (wr_data > exp_max_q) ? wr_data : exp_max_q;
          end
          if (go && (count_q != '0)) begin
            state_d = STREAM;
            start_d = 1'b1;
            data_d  = rd_data;
            idx_d   = CW'(1);
          end
        end
      end

      STREAM: begin
        // idx_q == count_q means the last stored value was presented in
        // the cycle now ending, so start drops from the next cycle.
        if (idx_q == count_q) begin
          state_d = WAIT;
          start_d = 1'b0;
          data_d  = '0;
          wcnt_d  = '0;
        end else begin
          data_d = rd_data;
          idx_d  = idx_q + CW'(1);
        end
      end

      WAIT: begin
        if (done) begin
          state_d        = RESULT;
          res_valid_d    = 1'b1;
          res_max_d      = max_val;
          res_timeout_d  = 1'b0;
          res_mismatch_d = (max_val != exp_max_q);
        end else if (wcnt_q == WAIT_LAST) begin
          state_d        = RESULT;
          res_valid_d    = 1'b1;
          res_max_d      = '0;
          res_timeout_d  = 1'b1;
          res_mismatch_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end

      RESULT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      idx_q          <= '0;
      wcnt_q         <= '0;
      exp_max_q      <= '0;
      start_q        <= 1'b0;
      data_q         <= '0;
      res_valid_q    <= 1'b0;
      res_max_q      <= '0;
      res_timeout_q  <= 1'b0;
      res_mismatch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      wcnt_q         <= wcnt_d;
      exp_max_q      <= exp_max_d;
      start_q        <= start_d;
      data_q         <= data_d;
      res_valid_q    <= res_valid_d;
      res_max_q      <= res_max_d;
      res_timeout_q  <= res_timeout_d;
      res_mismatch_q <= res_mismatch_d;
    end
  end

  assign count        = count_q;
  assign start        = start_q;
  assign data         = data_q;
  assign res_valid    = res_valid_q;
  assign res_max      = res_max_q;
  assign res_timeout  = res_timeout_q;
  assign res_mismatch = res_mismatch_q;

endmodule

// File: tb/tb_find_max_feeder.sv
// Bench for find_max_feeder with a behavioural find_max responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_find_max_feeder;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             clr;
  logic             go;
  logic [$clog2(DEPTH):0] count;
  logic             busy;
  logic             start;
  logic [WIDTH-1:0] data;
  logic             done;
  logic [WIDTH-1:0] max_val;
  logic             res_valid;
  logic [WIDTH-1:0] res_max;
  logic             res_timeout;
  logic             res_mismatch;

  always #5 clk = ~clk;

  find_max_feeder #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .clr          (clr),
    .go           (go),
    .count        (count),
    .busy         (busy),
    .start        (start),
    .data         (data),
    .done         (done),
    .max_val      (max_val),
    .res_valid    (res_valid),
    .res_max      (res_max),
    .res_timeout  (res_timeout),
    .res_mismatch (res_mismatch)
  );

  // Responder: 0 = well-behaved find_max, 1 = done never rises, 2 = reports 5.
  int               mode;
  logic             fm_work;
  logic [WIDTH-1:0] fm_max;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_work <= 1'b0;
      fm_max  <= '0;
    end else if (start) begin
      fm_max  <= (!fm_work || data > fm_max) ? data : fm_max;
      fm_work <= 1'b1;
    end else begin
      fm_work <= 1'b0;
    end
  end

  assign done    = (mode == 1) ? 1'b0 : (fm_work && !start);
  assign max_val = (mode == 2) ? WIDTH'(5) : fm_max;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int max;
    int timeout;
    int mismatch;
    int lat;
    int n;
  } exp_t;

  exp_t sb[$];
  int   exp_data[$];

  // Host-side model of the buffer contents.
  int m_buf[DEPTH];
  int m_cnt;

  int since_go;
  int go_armed;
  int run_starts;

  always @(negedge clk) begin
    if (rst_n) begin
      if (go_armed != 0) since_go++;
      if (start) begin
        if (run_starts == 0) check("first_start_cycle", since_go, 1);
        run_starts++;
        if (exp_data.size() == 0) check("stray_start", 1, 0);
        else check("stream_data", data, exp_data.pop_front());
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          check("stray_result", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_max", res_max, e.max);
          check("res_timeout", res_timeout, e.timeout);
          check("res_mismatch", res_mismatch, e.mismatch);
          check("res_latency", since_go, e.lat);
          check("start_cycles", run_starts, e.n);
          run_starts = 0;
          go_armed   = 0;
        end
      end
    end
  end

  task automatic wr(input int v);
    wr_en   = 1'b1;
    wr_data = WIDTH'(v);
    if (m_cnt < DEPTH) begin
      m_buf[m_cnt] = v;
      m_cnt++;
    end
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr   = 1'b1;
    m_cnt = 0;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic pulse_go();
    exp_t e;
    int   mx;
    mx = 0;
    if (m_cnt > 0) begin
      for (int i = 0; i < m_cnt; i++) begin
        exp_data.push_back(m_buf[i]);
        if (m_buf[i] > mx) mx = m_buf[i];
      end
      e.n = m_cnt;
      if (mode == 1) begin
        e.max = 0; e.timeout = 1; e.mismatch = 1; e.lat = m_cnt + TIMEOUT + 1;
      end else if (mode == 2) begin
        e.max = 5; e.timeout = 0; e.mismatch = (mx != 5) ? 1 : 0; e.lat = m_cnt + 2;
      end else begin
        e.max = mx; e.timeout = 0; e.mismatch = 0; e.lat = m_cnt + 2;
      end
      sb.push_back(e);
    end
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    if (m_cnt > 0) begin
      since_go = 0;
      go_armed = 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    check("result_arrived", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mode = 0; m_cnt = 0; since_go = 0; go_armed = 0; run_starts = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr = 1'b0; go = 1'b0;
    #3;
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_max", res_max, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_wr_ready", wr_ready, 1);

    // Basic run.
    wr(3); wr(9); wr(4); wr(1);
    check("count4", count, 4);
    pulse_go();
    drain();

    // Fill to capacity, overflow write dropped, replay.
    do_clr();
    for (int i = 0; i < DEPTH; i++) wr(i);
    check("full_wr_ready", wr_ready, 0);
    wr(99);
    check("full_count", count, DEPTH);
    pulse_go();
    drain();
    pulse_go();
    drain();

    // Single value, then clr and zero value.
    do_clr();
    check("clr_count", count, 0);
    wr(8'hFF);
    pulse_go();
    drain();
    do_clr();
    wr(0);
    pulse_go();
    drain();

    // done never arrives.
    mode = 1;
    do_clr();
    wr(6); wr(2);
    pulse_go();
    drain();

    // Faulty responder; host inputs while busy must be ignored.
    mode = 2;
    do_clr();
    wr(2); wr(7);
    pulse_go();
    go = 1'b1; wr_en = 1'b1; wr_data = 8'd99; clr = 1'b1;
    @(posedge clk);
    #1 go = 1'b0; wr_en = 1'b0; clr = 1'b0;
    check("busy_during_run", busy, 1);
    drain();
    check("count_after_busy_pulses", count, 2);
    mode = 0;

    // Reset during the second stream cycle.
    do_clr();
    wr(10); wr(20); wr(30);
    pulse_go();
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_data.delete();
    sb.delete();
    go_armed = 0;
    run_starts = 0;
    m_cnt = 0;
    #1;
    check("midrst_start", start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_go();
    repeat (6) @(posedge clk);
    #1;
    check("empty_go_busy", busy, 0);
    check("empty_go_start", start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
